// File: rtl/enchente_pkg.sv
// Shared types and defaults for the flood-response controller: state encoding,
// default parameters and the per-state output map.
package enchente_pkg;

    typedef enum logic [2:0] {
        NORMAL     = 3'd0,
        AVISO      = 3'd1,
        DRENAGEM   = 3'd2,
        ESPERA_ACK = 3'd3,
        FALHA      = 3'd7
    } estado_t;

    localparam int BLINK_HALF_DEF    = 4;
    localparam int PUMP_MIN_DEF      = 16;
    localparam int DRAIN_TIMEOUT_DEF = 256;
    localparam int CNT_W_DEF         = 9;

    typedef struct packed {
        logic entrada_bloqueada;
        logic estacionamento_fechado;
        logic bomba;
        logic sirene_fixa;
        logic falha;
    } saidas_t;

    // The AVISO blink is produced by sirene_pisca; only the steady siren lives here.
    function automatic saidas_t saidas_de(estado_t e);
        saidas_t s;
        s = '0;
        case (e)
            AVISO: begin
                s.entrada_bloqueada = 1'b1;
            end
            DRENAGEM: begin
                s.entrada_bloqueada      = 1'b1;
                s.estacionamento_fechado = 1'b1;
                s.bomba                  = 1'b1;
                s.sirene_fixa            = 1'b1;
            end
            ESPERA_ACK: begin
                s.entrada_bloqueada      = 1'b1;
                s.estacionamento_fechado = 1'b1;
            end
            FALHA: begin
                s.entrada_bloqueada      = 1'b1;
                s.estacionamento_fechado = 1'b1;
                s.bomba                  = 1'b1;
                s.sirene_fixa            = 1'b1;
                s.falha                  = 1'b1;
            end
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sirene_pisca.sv
// Siren blink timer: toggles every BLINK_HALF cycles while enabled, starting high
// on restart; held low while disabled.
module sirene_pisca
    import enchente_pkg::*;
#(
    parameter int BLINK_HALF = BLINK_HALF_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic restart_i,
    output logic pisca_o
);

    localparam int W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [W-1:0] cnt_q;
    logic         pisca_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            pisca_q <= 1'b0;
        end else if (restart_i) begin
            cnt_q   <= '0;
            pisca_q <= 1'b1;
        end else if (en_i) begin
            if (cnt_q == W'(BLINK_HALF - 1)) begin
                cnt_q   <= '0;
                pisca_q <= ~pisca_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            cnt_q   <= '0;
            pisca_q <= 1'b0;
        end
    end

    assign pisca_o = pisca_q;

endmodule

// File: rtl/controle_enchente.sv
// Flood-response controller: FSM plus dwell/timeout counter driving gate, siren and pump.
// Optional FLOOD_AUTO_REOPEN_EN: ESPERA_ACK also reopens after PUMP_MIN dry cycles.
module controle_enchente
    import enchente_pkg::*;
#(
    parameter int BLINK_HALF    = BLINK_HALF_DEF,
    parameter int PUMP_MIN      = PUMP_MIN_DEF,
    parameter int DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic alerta,
    input  logic emergencia,
    input  logic w10mm,
    input  logic ack,
    output logic entrada_bloqueada,
    output logic sirene,
    output logic bomba,
    output logic estacionamento_fechado,
    output logic falha
);

    estado_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    saidas_t          saidas_q;
    logic             pisca_en, pisca_restart, pisca;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            NORMAL: begin
                if (emergencia)  state_d = DRENAGEM;
                else if (alerta) state_d = AVISO;
            end
            AVISO: begin
                if (emergencia)  state_d = DRENAGEM;
                else if (!w10mm) state_d = NORMAL;
            end
            DRENAGEM: begin
                if (w10mm && cnt_q == CNT_W'(DRAIN_TIMEOUT - 1))
                    state_d = FALHA;
                else if (!w10mm && cnt_q >= CNT_W'(PUMP_MIN - 1))
                    state_d = ESPERA_ACK;
            end
            ESPERA_ACK: begin
                // In this state every cycle is dry, so the counter counts consecutive dry cycles.
                if (emergencia || w10mm) state_d = DRENAGEM;
                else if (ack)            state_d = NORMAL;
`ifdef FLOOD_AUTO_REOPEN_EN
                else if (cnt_q >= CNT_W'(PUMP_MIN - 1)) state_d = NORMAL;
`endif
            end
            FALHA:   state_d = FALHA;
            default: state_d = NORMAL;
        endcase

        if (state_d != state_q)
            cnt_d = '0;
        else if (cnt_q == {CNT_W{1'b1}})
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= NORMAL;
            cnt_q    <= '0;
            saidas_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            saidas_q <= saidas_de(state_d);
        end
    end

    assign pisca_en      = (state_d == AVISO);
    assign pisca_restart = pisca_en && (state_q != AVISO);

    sirene_pisca #(
        .BLINK_HALF(BLINK_HALF)
    ) u_pisca (
        .clk      (clk),
        .rst_n    (reset),
        .en_i     (pisca_en),
        .restart_i(pisca_restart),
        .pisca_o  (pisca)
    );

    assign entrada_bloqueada      = saidas_q.entrada_bloqueada;
    assign estacionamento_fechado = saidas_q.estacionamento_fechado;
    assign bomba                  = saidas_q.bomba;
    assign falha                  = saidas_q.falha;
    assign sirene                 = saidas_q.sirene_fixa | pisca;

endmodule

// File: tb/tb_controle_enchente.sv
// Self-checking bench for controle_enchente: directed scenarios plus randomized
// traffic compared against a behavioural model of the response sequence.
module tb_controle_enchente;

    localparam int BH = 4;
    localparam int PM = 16;
    localparam int DT = 256;
    localparam int CW = 9;
`ifdef FLOOD_AUTO_REOPEN_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    // Output vector order: {entrada, sirene, bomba, fechado, falha}
    localparam logic [4:0] O_IDLE = 5'b00000;
    localparam logic [4:0] O_DREN = 5'b11110;
    localparam logic [4:0] O_ESPR = 5'b10010;
    localparam logic [4:0] O_FALH = 5'b11111;

    localparam int MN = 0, MA = 1, MD = 2, ME = 3, MF = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic alerta = 1'b0, emergencia = 1'b0, w10mm = 1'b0, ack = 1'b0;
    logic entrada_bloqueada, sirene, bomba, estacionamento_fechado, falha;
    logic [4:0] saida;

    int total = 0;
    int passed = 0;
    int m_mode = MN;
    int m_t = 0;

    controle_enchente #(
        .BLINK_HALF(BH), .PUMP_MIN(PM), .DRAIN_TIMEOUT(DT), .CNT_W(CW)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .alerta                (alerta),
        .emergencia            (emergencia),
        .w10mm                 (w10mm),
        .ack                   (ack),
        .entrada_bloqueada     (entrada_bloqueada),
        .sirene                (sirene),
        .bomba                 (bomba),
        .estacionamento_fechado(estacionamento_fechado),
        .falha                 (falha)
    );

    assign saida = {entrada_bloqueada, sirene, bomba, estacionamento_fechado, falha};

    always #5 clk = ~clk;

    function void model_reset();
        m_mode = MN;
        m_t    = 0;
    endfunction

    // m_t = completed cycles spent in the current mode
    function void model_step();
        int nm;
        nm = m_mode;
        case (m_mode)
            MN: if (emergencia) nm = MD; else if (alerta) nm = MA;
            MA: if (emergencia) nm = MD; else if (!w10mm) nm = MN;
            MD: if (w10mm && (m_t + 1 == DT)) nm = MF;
                else if (!w10mm && (m_t + 1 >= PM)) nm = ME;
            ME: if (emergencia || w10mm) nm = MD;
                else if (ack) nm = MN;
                else if (AUTO && (m_t + 1 >= PM)) nm = MN;
            default: nm = m_mode;
        endcase
        if (nm != m_mode) begin
            m_mode = nm;
            m_t    = 0;
        end else begin
            m_t++;
        end
    endfunction

    function logic [4:0] model_out();
        case (m_mode)
            MA:      return {1'b1, ((m_t / BH) % 2 == 0), 3'b000};
            MD:      return O_DREN;
            ME:      return O_ESPR;
            MF:      return O_FALH;
            default: return O_IDLE;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        alerta = 1'b0; emergencia = 1'b0; w10mm = 1'b0; ack = 1'b0;
        reset = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        total++;
        if (saida !== O_IDLE) $display("FAIL reset_async got=%b exp=%b", saida, O_IDLE);
        else passed++;
        model_reset();
        @(posedge clk);
        #1;
        total++;
        if (saida !== O_IDLE) $display("FAIL reset_held got=%b exp=%b", saida, O_IDLE);
        else passed++;
        #2 reset = 1'b1;
        tick();
        total++;
        if (saida !== O_IDLE) $display("FAIL reset_idle got=%b exp=%b", saida, O_IDLE);
        else passed++;
    endtask

    task automatic test_aviso();
        do_reset();
        repeat (3) tick();
        w10mm = 1'b1;
        alerta = 1'b1;
        tick();
        alerta = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) tick();
            total++;
            if (saida !== {1'b1, (i < 4), 3'b000})
                $display("FAIL aviso_blink i=%0d got=%b exp=%b", i, saida, {1'b1, (i < 4), 3'b000});
            else passed++;
            alerta = (i == 1);
        end
        alerta = 1'b0;
        w10mm = 1'b0;
        tick();
        total++;
        if (saida !== O_IDLE) $display("FAIL aviso_exit got=%b exp=%b", saida, O_IDLE);
        else passed++;
    endtask

    task automatic test_emergencia_simultanea();
        do_reset();
        w10mm = 1'b1;
        alerta = 1'b1;
        emergencia = 1'b1;
        tick();
        alerta = 1'b0;
        emergencia = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i != 0) tick();
            total++;
            if (saida !== O_DREN) $display("FAIL simult_dren i=%0d got=%b exp=%b", i, saida, O_DREN);
            else passed++;
        end
    endtask

    task automatic test_dwell_minimo();
        logic [4:0] exp;
        do_reset();
        w10mm = 1'b1;
        emergencia = 1'b1;
        tick();
        emergencia = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            if (i != 0) tick();
            exp = (i < 16) ? O_DREN : O_ESPR;
            total++;
            if (saida !== exp) $display("FAIL dwell i=%0d got=%b exp=%b", i, saida, exp);
            else passed++;
            if (i == 2) w10mm = 1'b0;
            emergencia = (i == 5);
        end
        emergencia = 1'b0;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        total++;
        if (saida !== O_IDLE) $display("FAIL dwell_ack got=%b exp=%b", saida, O_IDLE);
        else passed++;
    endtask

    task automatic test_timeout_falha();
        do_reset();
        w10mm = 1'b1;
        emergencia = 1'b1;
        tick();
        emergencia = 1'b0;
        for (int i = 1; i <= 255; i++) tick();
        total++;
        if (saida !== O_DREN) $display("FAIL timeout_early got=%b exp=%b", saida, O_DREN);
        else passed++;
        tick();
        total++;
        if (saida !== O_FALH) $display("FAIL timeout_fault got=%b exp=%b", saida, O_FALH);
        else passed++;
        ack = 1'b1;
        w10mm = 1'b0;
        repeat (5) tick();
        ack = 1'b0;
        total++;
        if (saida !== O_FALH) $display("FAIL fault_sticky got=%b exp=%b", saida, O_FALH);
        else passed++;
        #2 reset = 1'b0;
        #1;
        model_reset();
        total++;
        if (saida !== O_IDLE) $display("FAIL fault_reset got=%b exp=%b", saida, O_IDLE);
        else passed++;
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic test_reset_assincrono();
        do_reset();
        w10mm = 1'b1;
        emergencia = 1'b1;
        tick();
        emergencia = 1'b0;
        repeat (5) tick();
        total++;
        if (saida !== O_DREN) $display("FAIL mid_dren got=%b exp=%b", saida, O_DREN);
        else passed++;
        #2 reset = 1'b0;
        #1;
        model_reset();
        total++;
        if (saida !== O_IDLE) $display("FAIL async_clear got=%b exp=%b", saida, O_IDLE);
        else passed++;
        @(posedge clk);
        #2 reset = 1'b1;
        tick();
        total++;
        if (saida !== O_IDLE) $display("FAIL async_release got=%b exp=%b", saida, O_IDLE);
        else passed++;
        alerta = 1'b1;
        tick();
        alerta = 1'b0;
        total++;
        if (saida !== 5'b11000) $display("FAIL async_resume got=%b exp=%b", saida, 5'b11000);
        else passed++;
    endtask

    task automatic test_reentrada();
        logic [4:0] exp;
        do_reset();
        w10mm = 1'b1;
        emergencia = 1'b1;
        tick();
        emergencia = 1'b0;
        w10mm = 1'b0;
        repeat (16) tick();
        total++;
        if (saida !== O_ESPR) $display("FAIL reent_espera got=%b exp=%b", saida, O_ESPR);
        else passed++;
        w10mm = 1'b1;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        w10mm = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            if (i != 0) tick();
            exp = (i < 16) ? O_DREN : O_ESPR;
            total++;
            if (saida !== exp) $display("FAIL reent_dwell i=%0d got=%b exp=%b", i, saida, exp);
            else passed++;
        end
        for (int j = 1; j <= 24; j++) begin
            tick();
            exp = (AUTO && j >= 16) ? O_IDLE : O_ESPR;
            total++;
            if (saida !== exp) $display("FAIL reopen j=%0d got=%b exp=%b", j, saida, exp);
            else passed++;
        end
    endtask

    task automatic test_aleatorio();
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if (m_mode == MF && m_t > 8) do_reset();
            alerta     = ($urandom_range(0, 7) == 0);
            emergencia = ($urandom_range(0, 40) == 0);
            ack        = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) w10mm = ~w10mm;
            tick();
            total++;
            if (saida !== model_out())
                $display("FAIL random n=%0d mode=%0d t=%0d got=%b exp=%b", n, m_mode, m_t, saida, model_out());
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_aviso();
        test_emergencia_simultanea();
        test_dwell_minimo();
        test_timeout_falha();
        test_reset_assincrono();
        test_reentrada();
        test_aleatorio();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/controle_enchente.md
# controle_enchente

Flood-response controller for the parking lot; the consuming end of the water-level monitor's `alerta`/`emergencia` outputs. It sequences the physical response: entry blocking, siren, drain pump, lot closure and operator-acknowledged reopening. It sits between the water-level monitor and the gate, siren and pump drivers.

## Interface
- `BLINK_HALF`, 4: siren half-period in AVISO, in clk cycles (≥1).
- `PUMP_MIN`, 16: minimum pump run, in cycles, before a drained lot is accepted.
- `DRAIN_TIMEOUT`, 256: cycles in DRENAGEM before declaring a fault (> `PUMP_MIN`).
- `CNT_W`, 9: counter width; must hold `DRAIN_TIMEOUT`.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: **asynchronous, active-low** reset.
- `alerta` in 1: single-cycle or level pulse from the monitor; water reached 20 mm.
- `emergencia` in 1: pulse from the monitor; lot empty and still flooded.
- `w10mm` in 1: raw 10 mm sensor; 1 = water at or above 10 mm.
- `ack` in 1: operator reopen request, level-sampled.
- `entrada_bloqueada` out 1: entry gate held closed.
- `sirene` out 1: siren drive.
- `bomba` out 1: drain pump on.
- `estacionamento_fechado` out 1: lot closed to all traffic.
- `falha` out 1: drain fault latched.

## Operation
- States: NORMAL, AVISO, DRENAGEM, ESPERA_ACK, FALHA. Reset → NORMAL, counter 0, all outputs 0.
- NORMAL: all outputs 0. `emergencia` → DRENAGEM; else `alerta` → AVISO.
- AVISO: `entrada_bloqueada`=1; `sirene` toggles every `BLINK_HALF` cycles, first half-period high. `emergencia` → DRENAGEM. `w10mm`=0 → NORMAL. Repeated `alerta` is ignored.
- DRENAGEM: `entrada_bloqueada`=`estacionamento_fechado`=`bomba`=`sirene`=1 (siren steady). Counter increments each cycle from 0, saturating. `w10mm`=0 with counter ≥ `PUMP_MIN`−1 → ESPERA_ACK. Counter = `DRAIN_TIMEOUT`−1 with `w10mm`=1 → FALHA. Repeated `emergencia` does not restart the counter.
- ESPERA_ACK: `entrada_bloqueada`=`estacionamento_fechado`=1, `bomba`=`sirene`=0. `w10mm`=1 → DRENAGEM with counter cleared (priority over `ack`). `ack`=1 → NORMAL.
- FALHA: `bomba`=`sirene`=`falha`=`estacionamento_fechado`=`entrada_bloqueada`=1. Exited only by `reset`.
- Priority on simultaneous inputs: `emergencia` > `w10mm` re-rise > `ack` > `alerta`.
- Counter clears on every state entry. It saturates and never wraps.

## Timing
- Inputs are sampled on rising `clk`. State and all outputs are registered, so an output change appears one cycle after the causing input is sampled.
- `alerta` or `emergencia` asserted for exactly one cycle must be captured.
- Minimum DRENAGEM dwell is `PUMP_MIN` cycles, even if `w10mm` is already 0 on entry.
- Fault occurs exactly `DRAIN_TIMEOUT` cycles after DRENAGEM entry.
- Reset assertion mid-operation forces all outputs to 0 immediately (asynchronous). Release is synchronous to the next `clk` edge.
- The siren phase restarts on each AVISO entry.

## Configuration
- `FLOOD_AUTO_REOPEN_EN` defined: ESPERA_ACK also returns to NORMAL after `PUMP_MIN` consecutive cycles of `w10mm`=0, without `ack`. `ack` still reopens immediately.
- `FLOOD_AUTO_REOPEN_EN` undefined: reopening requires `ack`; the lot stays closed indefinitely otherwise.

## Structure
- Package `enchente_pkg`:
  - state encoding constants: NORMAL=0, AVISO=1, DRENAGEM=2, ESPERA_ACK=3, FALHA=7;
  - default parameter constants.
- Sub-module `sirene_pisca`: a `BLINK_HALF` toggle timer with an enable/restart input, instantiated once. The top level holds the FSM and the dwell/timeout counter.

## Test plan
- `alerta` one-cycle pulse at cycle 10, `w10mm`=1 → `entrada_bloqueada`=1 at cycle 11; `sirene` high for cycles 11–14 and low for 15–18. `w10mm`→0 → NORMAL next cycle with all outputs 0.
- `alerta` and `emergencia` in the same cycle → DRENAGEM: `bomba`=`estacionamento_fechado`=1 next cycle, with no AVISO blink.
- DRENAGEM with `w10mm` dropping at cycle 3 → stays pumping until the counter reaches 15, then ESPERA_ACK. `ack` → NORMAL one cycle later.
- DRENAGEM with `w10mm` held at 1 → `falha`=1 exactly 256 cycles after entry. `ack` is ignored; only `reset` low clears it.
- ESPERA_ACK, `w10mm` and `ack` rise in the same cycle → DRENAGEM with the counter restarted at 0. The build with `FLOOD_AUTO_REOPEN_EN` → NORMAL after 16 dry cycles with no `ack`.
- `reset` pulled low mid-DRENAGEM between clock edges → all outputs 0 without waiting for `clk`. After release, NORMAL.
